// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  writeRegisterIndex,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  resultRegisterIndex
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rdx_q, rdx_d;

  // Operand conditioning at accept: signedness, magnitudes, corners
  logic        is_div;
  logic        a_sgn, b_sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div0, ovf;
  logic [31:0] early_res;

  // Per-iteration datapath
  logic [32:0] sum33;
  logic [63:0] mul_nx;
  logic [32:0] rs;
  logic        ge;
  logic [31:0] dsub;
  logic [63:0] div_nx;
  logic [63:0] fin_p;
  logic [31:0] mul_res;
  logic [31:0] q_nx, r_nx;
  logic [31:0] div_res;

  // Decode the request and precompute the short-circuit results
  always_comb begin
    is_div = funct3[2];
    a_sgn  = is_div ? ~funct3[0]
                    : (funct3 == 3'b001) | (funct3 == 3'b010);
    b_sgn  = is_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg  = a_sgn & lhs[31];
    b_neg  = b_sgn & rhs[31];
    a_mag  = a_neg ? (32'd0 - lhs) : lhs;
    b_mag  = b_neg ? (32'd0 - rhs) : rhs;
    div0   = is_div & (rhs == 32'd0);
    ovf    = is_div & ~funct3[0]
           & (lhs == 32'h8000_0000)
           & (rhs == 32'hFFFF_FFFF);
    if (div0)
      early_res = funct3[1] ? lhs : 32'hFFFF_FFFF;
    else
      early_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One multiply step and one divide step, plus final sign fix-up
  always_comb begin
    sum33  = {1'b0, acc_q[63:32]}
           + {1'b0, (acc_q[0] ? b_q : 32'd0)};
    mul_nx = {sum33, acc_q[31:1]};
    rs     = acc_q[63:31];
    ge     = rs >= {1'b0, b_q};
    dsub   = rs[31:0] - b_q;
    div_nx = {(ge ? dsub : rs[31:0]), acc_q[30:0], ge};
    fin_p  = neg_q ? (64'd0 - mul_nx) : mul_nx;
    mul_res = (op_q == 3'b000) ? fin_p[31:0] : fin_p[63:32];
    q_nx   = div_nx[31:0];
    r_nx   = div_nx[63:32];
    if (op_q[1])
      div_res = rneg_q ? (32'd0 - r_nx) : r_nx;
    else
      div_res = neg_q ? (32'd0 - q_nx) : q_nx;
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    rd_d    = rd_q;
    res_d   = res_q;
    rdx_d   = rdx_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = funct3;
          rd_d   = writeRegisterIndex;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = 5'd0;
          if (div0 || ovf) begin
            state_d = DONE;
            res_d   = early_res;
            rdx_d   = writeRegisterIndex;
          end else if (is_div) begin
            state_d = DIV;
            acc_d   = {32'd0, a_mag};
            b_d     = b_mag;
          end else begin
            state_d = MUL;
            acc_d   = {32'd0, b_mag};
            b_d     = a_mag;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = mul_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            res_d   = mul_res;
            rdx_d   = rd_q;
          end
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = div_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            res_d   = div_res;
            rdx_d   = rd_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      rd_q    <= 5'd0;
      res_q   <= 32'd0;
      rdx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      rdx_q   <= rdx_d;
    end
  end

  // Pipeline back-pressure and result strobe
  always_comb begin
    stall = ~rst & (((state_q == IDLE) & start)
                    | (state_q == MUL)
                    | (state_q == DIV));
    done  = ~rst & ~flush & (state_q == DONE);
    result = res_q;
    resultRegisterIndex = rdx_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit.
// Directed corners plus random ops against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  writeRegisterIndex;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  resultRegisterIndex;

  int n_chk;
  int n_pass;

  ex_muldiv_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .funct3              (funct3),
    .lhs                 (lhs),
    .rhs                 (rhs),
    .writeRegisterIndex  (writeRegisterIndex),
    .flush               (flush),
    .stall               (stall),
    .done                (done),
    .result              (result),
    .resultRegisterIndex (resultRegisterIndex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = 64'sd0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input string tag,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd);
    int lat;
    int bad;
    lat = ref_lat(f, a, b);
    bad = 0;
    @(negedge clk);
    funct3 = f; lhs = a; rhs = b;
    writeRegisterIndex = rd; start = 1'b1;
    #1 check({tag, "_stall_acc"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    lhs = $urandom; rhs = $urandom;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n < lat) begin
        if (done !== 1'b0 || stall !== 1'b1) bad++;
      end else if (n == lat) begin
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_res"}, result, ref_res(f, a, b));
        check({tag, "_rd"}, {27'd0, resultRegisterIndex},
              {27'd0, rd});
        check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
      end else begin
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
      end
    end
    check({tag, "_busy_cycles"}, bad, 0);
  endtask

  task automatic abort_test(input string tag, input bit use_rst);
    int dn;
    int st;
    dn = 0; st = 0;
    @(negedge clk);
    funct3 = 3'd0; lhs = 32'd1234; rhs = 32'd5678;
    writeRegisterIndex = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    #1 check({tag, "_stall_abort"}, {31'd0, stall},
             {31'd0, ~use_rst});
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) dn++;
      if (stall) st++;
    end
    check({tag, "_no_done"}, dn, 0);
    check({tag, "_no_stall"}, st, 0);
    if (use_rst) begin
      check({tag, "_res_clr"}, result, 32'd0);
      check({tag, "_rd_clr"}, {27'd0, resultRegisterIndex}, 32'd0);
    end
    run_op({tag, "_mul3x3"}, 3'd0, 32'd3, 32'd3, 5'd11);
  endtask

  task automatic held_start_test();
    int dn;
    int first;
    int second;
    dn = 0; first = 0; second = 0;
    @(negedge clk);
    funct3 = 3'd0; lhs = 32'd2; rhs = 32'd5;
    writeRegisterIndex = 5'd3; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (first == 0) first = n; else second = n;
      end
      if (n == 34)
        check("held_stall_idle", {31'd0, stall}, 32'd1);
      if (n == 35) start = 1'b0;
    end
    check("held_dones", dn, 2);
    check("held_first", first, 33);
    check("held_second", second, 67);
    check("held_res", result, 32'd10);
  endtask

  task automatic flush_start_test();
    int dn;
    dn = 0;
    @(negedge clk);
    funct3 = 3'd0; lhs = 32'd4; rhs = 32'd4;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fs_no_accept_stall", {31'd0, stall}, 32'd0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("fs_no_done", dn, 0);
  endtask

  function automatic logic [31:0] pick(input bit divisor);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return divisor ? 32'd0 : 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; lhs = 32'd0; rhs = 32'd0;
    writeRegisterIndex = 5'd0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("por_stall", {31'd0, stall}, 32'd0);
    check("por_done", {31'd0, done}, 32'd0);
    check("por_res", result, 32'd0);
    check("por_rd", {27'd0, resultRegisterIndex}, 32'd0);

    run_op("mul7x6", 3'd0, 32'd7, 32'd6, 5'd17);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    check("mulh_val", result, 32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    check("mulhsu_val", result, 32'hFFFF_FFFF);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    check("mulhu_val", result, 32'hFFFF_FFFE);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    check("div_val", result, 32'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    check("rem_val", result, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd6);
    check("divu_val", result, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd7);
    check("remu_val", result, 32'd2);
    run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd8);
    check("divu0_val", result, 32'hFFFF_FFFF);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd9);
    check("rem0_val", result, 32'd5);
    run_op("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    check("divov_val", result, 32'h8000_0000);
    run_op("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    check("remov_val", result, 32'd0);

    abort_test("flush", 1'b0);
    abort_test("rst", 1'b1);
    held_start_test();
    flush_start_test();

    for (int i = 0; i < 60; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick(1'b0);
      b = pick(1'b1);
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b,
             5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start  input  1  EX-stage request, valid with operands, funct3 and index.
REQ-004 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port lhs  input  32  rs1 operand value.
REQ-006 SHALL have port rhs  input  32  rs2 operand value.
REQ-007 SHALL have port writeRegisterIndex  input  5  rd of the requesting instruction.
REQ-008 SHALL have port flush  input  1  abort of the in-flight operation (branch taken).
REQ-009 SHALL have port stall  output  1  back-pressure to the PC, IF/ID and ID/EX pipeline registers: hold contents.
REQ-010 SHALL have port done  output  1  one-cycle result-valid strobe.
REQ-011 SHALL have port result  output  32  operation result, valid only while done=1.
REQ-012 SHALL have port resultRegisterIndex  output  5  rd captured at accept, valid while done=1.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-014 SHALL accept a request only when state=IDLE and start=1 and flush=0; accept registers lhs, rhs, funct3 and writeRegisterIndex internally.
REQ-015 SHALL ignore start in MUL, DIV and DONE; no queuing.
REQ-016 SHALL drive stall=1 combinationally when (IDLE and start=1) or state is MUL or DIV; stall=0 in DONE and in IDLE without start.
REQ-017 SHALL transition IDLE->MUL for funct3[2]=0 and IDLE->DIV for funct3[2]=1, except as REQ-023 states.
REQ-018 SHALL perform one radix-2 iteration per cycle with a 5-bit counter; exactly 32 iterations; the edge completing iteration 31 moves the state to DONE and registers result.
REQ-019 SHALL assert done=1 for exactly one cycle, the cycle after the 32nd iteration edge, i.e. 33 cycles after the accept edge; DONE->IDLE unconditionally on the next edge.
REQ-020 SHALL multiply operand magnitudes into a 64-bit unsigned product: MUL returns product[31:0]; MULH treats both operands as signed, MULHSU treats lhs as signed and rhs as unsigned, and MULHU treats both as unsigned; MULH, MULHSU and MULHU return [63:32] of the sign-corrected 64-bit product.
REQ-021 SHALL divide by restoring division on magnitudes: DIV/REM signed, DIVU/REMU unsigned; quotient sign = sign(lhs) XOR sign(rhs); remainder sign = sign(lhs); quotient truncates toward zero.
REQ-022 SHALL on divide-by-zero (rhs=0) return 0xFFFFFFFF for DIV/DIVU and lhs for REM/REMU.
REQ-023 SHALL on divide-by-zero or signed overflow (DIV/REM, lhs=0x80000000, rhs=0xFFFFFFFF) go IDLE->DONE directly, with done asserted 1 cycle after the accept edge; overflow returns 0x80000000 for DIV and 0 for REM.
REQ-024 SHALL on flush=1 in MUL, DIV or DONE return to IDLE on that edge; done is suppressed (0) in that cycle and no result is produced.
REQ-025 SHALL give flush priority over start in the same cycle: no accept.
REQ-026 SHALL hold result and resultRegisterIndex stable outside DONE; only the done cycle is meaningful.

Reset
REQ-027 SHALL on rst=1 at a clock edge enter IDLE and clear counter, result=0, resultRegisterIndex=0, done=0, irrespective of state; rst has priority over flush and start.
REQ-028 SHALL drive stall=0 while rst=1 and in the first cycle after reset unless start=1.
REQ-029 SHALL abort an in-flight operation on rst without asserting done.

Verification
REQ-030 SHALL cover MUL lhs=7, rhs=6 -> stall high from the accept cycle through the cycle before done, done exactly 33 cycles after the accept edge, result=42, resultRegisterIndex=captured rd.
REQ-031 SHALL cover high multiplies -> MULH 0x80000000*0x80000000 gives 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE.
REQ-032 SHALL cover signed division -> DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100/7 gives 2.
REQ-033 SHALL cover corner cases -> DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM 0x80000000/0xFFFFFFFF gives 0; each case asserts done 1 cycle after accept.
REQ-034 SHALL cover aborts -> flush at iteration 10 returns the block to IDLE, done never asserts and stall drops; then a new MUL 3*3 is accepted and gives 9. Repeat the same sequence with rst instead of flush.
REQ-035 SHALL cover start held high during DONE -> the request is not accepted in DONE; it is accepted in the following IDLE cycle and yields exactly one further done.
